// File: rtl/uart_rx_fifo_if.sv
// Byte stream and status bundle between the UART RX buffer and the system side.
// Pure wiring, no latency.
// Producer side has no backpressure; consumer side uses valid/ready.
interface uart_rx_fifo_if #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
);
  logic                     in_valid;
  logic [DATA_WIDTH-1:0]    in_data;
  logic                     in_error;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH-1:0]    out_data;
  logic                     out_error;
  logic                     flush;
  logic [$clog2(DEPTH):0]   level;
  logic                     empty;
  logic                     full;
  logic                     overflow;
  logic                     overflow_clear;
  logic [CNT_WIDTH-1:0]     drop_count;

  // FIFO side
  modport slave (
    input  in_valid, in_data, in_error, out_ready, flush, overflow_clear,
    output out_valid, out_data, out_error, level, empty, full, overflow, drop_count
  );

  // UART / system side
  modport master (
    output in_valid, in_data, in_error, out_ready, flush, overflow_clear,
    input  out_valid, out_data, out_error, level, empty, full, overflow, drop_count
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// FWFT receive buffer behind the UART RX path with overflow detection and drop counting.
// Latency: a byte pushed at edge N is on out_data after edge N; no same-cycle bypass.
// Input cannot be stalled: bytes arriving while full (and not popping) are dropped and counted.
module uart_rx_fifo #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0]        P_ONE = PW'(1);
  localparam logic [CNT_WIDTH-1:0] C_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] C_MAX = '1;

  // {error, data} per entry; contents are don't-care until written
  logic [DATA_WIDTH:0]     mem [DEPTH];

  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]           level_q, level_d;
  logic                    overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0]    drop_cnt_q, drop_cnt_d;

  logic                    empty, full, pop, push, drop;
  logic [DATA_WIDTH:0]     head;

  // Wrap bit distinguishes full from empty when the index bits match
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign pop  = !empty && bus.out_ready;
  assign push = bus.in_valid && (!full || pop) && !bus.flush;
  assign drop = bus.in_valid && full && !pop && !bus.flush;

  // Head mux depends only on registered state, so out_ready never reaches an output
  assign head = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

  assign bus.out_valid  = !empty;
  assign bus.out_data   = head[DATA_WIDTH-1:0];
  assign bus.out_error  = head[DATA_WIDTH];
  assign bus.level      = level_q;
  assign bus.empty      = empty;
  assign bus.full       = full;
  assign bus.overflow   = overflow_q;
  assign bus.drop_count = drop_cnt_q;

  // Next-state: flush beats push/pop; a drop beats overflow_clear
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + P_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + P_ONE;
      if (push && !pop)      level_d = level_q + P_ONE;
      else if (pop && !push) level_d = level_q - P_ONE;
    end

    if (drop) begin
      overflow_d = 1'b1;
      if (bus.overflow_clear)     drop_cnt_d = C_ONE;
      else if (drop_cnt_q != C_MAX) drop_cnt_d = drop_cnt_q + C_ONE;
    end else if (bus.overflow_clear) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  // Control state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage write; no reset so the array can map onto plain RAM
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= {bus.in_error, bus.in_data};
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: vector table plus hand-written multi-cycle sequences.
// Inputs change on the falling edge; outputs are compared on the falling edge after each rise.
// Expected values come from the table, constants, or a queue scoreboard.
module tb_uart_rx_fifo;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  uart_rx_fifo_if #(.DEPTH(16), .DATA_WIDTH(8), .CNT_WIDTH(8)) bus ();

  uart_rx_fifo #(.DEPTH(16), .DATA_WIDTH(8), .CNT_WIDTH(8)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ie;
    logic       rdy;
    logic       fl;
    logic       oc;
    logic       ev;
    logic [7:0] ed;
    logic       ee;
    logic [4:0] el;
    logic       eovf;
    logic [7:0] ecnt;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic ev, input logic [7:0] ed, input logic ee,
                           input logic [4:0] el, input logic eovf, input logic [7:0] ecnt);
    check({tag, ".out_valid"},  bus.out_valid,  ev);
    check({tag, ".out_data"},   bus.out_data,   ed);
    check({tag, ".out_error"},  bus.out_error,  ee);
    check({tag, ".level"},      bus.level,      el);
    check({tag, ".empty"},      bus.empty,      el == 5'd0);
    check({tag, ".full"},       bus.full,       el == 5'd16);
    check({tag, ".overflow"},   bus.overflow,   eovf);
    check({tag, ".drop_count"}, bus.drop_count, ecnt);
  endtask

  task automatic set_in(input logic iv, input logic [7:0] d, input logic e,
                        input logic rdy, input logic fl, input logic oc);
    bus.in_valid       = iv;
    bus.in_data        = d;
    bus.in_error       = e;
    bus.out_ready      = rdy;
    bus.flush          = fl;
    bus.overflow_clear = oc;
  endtask

  // One clock with the given inputs, then back to idle at the falling edge
  task automatic cyc(input logic iv, input logic [7:0] d, input logic e,
                     input logic rdy, input logic fl, input logic oc);
    set_in(iv, d, e, rdy, fl, oc);
    @(posedge clk);
    @(negedge clk);
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [8:0] q [$];
    logic [8:0] hd;
    logic [7:0] exp_d;
    int         sent;
    int         c;
    logic       iv, rdy, exp_pop;

    checks = 0;
    errors = 0;

    //          iv  id     ie  rdy fl  oc    ev  ed     ee  el  ovf cnt
    vecs[0]  = '{1, 8'h55, 0,  0,  0,  0,    1, 8'h55, 0,  1,  0,  0};
    vecs[1]  = '{0, 8'h00, 0,  1,  0,  0,    0, 8'h00, 0,  0,  0,  0};
    vecs[2]  = '{1, 8'hA5, 1,  0,  0,  0,    1, 8'hA5, 1,  1,  0,  0};
    vecs[3]  = '{1, 8'h3C, 0,  0,  0,  0,    1, 8'hA5, 1,  2,  0,  0};
    vecs[4]  = '{1, 8'hC3, 1,  1,  0,  0,    1, 8'h3C, 0,  2,  0,  0};
    vecs[5]  = '{0, 8'h00, 0,  1,  0,  0,    1, 8'hC3, 1,  1,  0,  0};
    vecs[6]  = '{0, 8'h00, 0,  1,  0,  0,    0, 8'h00, 0,  0,  0,  0};
    vecs[7]  = '{0, 8'h00, 0,  1,  0,  0,    0, 8'h00, 0,  0,  0,  0};
    vecs[8]  = '{1, 8'h11, 1,  0,  1,  0,    0, 8'h00, 0,  0,  0,  0};
    vecs[9]  = '{1, 8'h22, 0,  1,  0,  0,    1, 8'h22, 0,  1,  0,  0};
    vecs[10] = '{0, 8'h00, 0,  0,  0,  0,    1, 8'h22, 0,  1,  0,  0};
    vecs[11] = '{0, 8'h00, 0,  1,  1,  0,    0, 8'h00, 0,  0,  0,  0};
    vecs[12] = '{0, 8'h00, 0,  0,  0,  1,    0, 8'h00, 0,  0,  0,  0};

    // Reset state
    reset = 1'b0;
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk_state("reset", 0, 8'h00, 0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);

    // Single-step vectors: FWFT, pop/push overlap, ready-while-empty, flush, no bypass
    for (int i = 0; i < 13; i++) begin
      cyc(vecs[i].iv, vecs[i].id, vecs[i].ie, vecs[i].rdy, vecs[i].fl, vecs[i].oc);
      chk_state($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].ee,
                vecs[i].el, vecs[i].eovf, vecs[i].ecnt);
    end

    // Fill, drop when full, then push+pop at full
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk_state("fill", 1, 8'h00, 0, 16, 0, 0);
    cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_state("drop1", 1, 8'h00, 0, 16, 1, 1);
    cyc(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_state("full_pp", 1, 8'h01, 0, 16, 1, 1);
    for (int i = 0; i < 16; i++) begin
      exp_d = (i < 15) ? 8'(i + 1) : 8'h77;
      check($sformatf("drain%0d.valid", i), bus.out_valid, 1'b1);
      check($sformatf("drain%0d.data", i), bus.out_data, exp_d);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    chk_state("drained", 0, 8'h00, 0, 0, 1, 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_state("clr0", 0, 8'h00, 0, 0, 0, 0);

    // Wrap-around stream with alternating error flag and toggling ready
    sent = 0;
    c = 0;
    while ((sent < 40 || q.size() != 0) && c < 300) begin
      iv  = (sent < 40) && (c % 3 != 2);
      rdy = (c % 2 == 0) || (sent >= 40);
      exp_pop = rdy && (q.size() != 0);
      check("strm.valid", bus.out_valid, q.size() != 0);
      if (exp_pop) begin
        hd = q.pop_front();
        check("strm.data", bus.out_data, hd[7:0]);
        check("strm.err", bus.out_error, hd[8]);
      end
      if (iv) begin
        if (q.size() < 16) q.push_back({1'(sent % 2), 8'(8'h80 + sent)});
        cyc(1'b1, 8'(8'h80 + sent), 1'(sent % 2), rdy, 1'b0, 1'b0);
        sent++;
      end else begin
        cyc(1'b0, 8'h00, 1'b0, rdy, 1'b0, 1'b0);
      end
      check("strm.level", bus.level, q.size());
      check("strm.lvl_bound", bus.level <= 5'd16, 1'b1);
      c++;
    end
    check("strm.done", c < 300, 1'b1);
    chk_state("strm_end", 0, 8'h00, 0, 0, 0, 0);

    // Counter saturation and clear-versus-drop priority
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) cyc(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_state("sat", 1, 8'hB0, 0, 16, 1, 255);
    cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_state("clr_drop", 1, 8'hB0, 0, 16, 1, 1);

    // Flush: alone, then with a byte presented at level 5
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_state("flush_a", 0, 8'h00, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'hD0 + i), 1'(i % 2), 1'b0, 1'b0, 1'b0);
    chk_state("lvl5", 1, 8'hD0, 0, 5, 1, 1);
    cyc(1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_state("flush_b", 0, 8'h00, 0, 0, 1, 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_state("no33", 0, 8'h00, 0, 0, 1, 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_state("clr_alone", 0, 8'h00, 0, 0, 0, 0);

    // Refill, then asynchronous reset between clock edges
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'hE0 + i), 1'b1, 1'b0, 1'b0, 1'b0);
    chk_state("refill", 1, 8'hE0, 1, 3, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    chk_state("arst", 0, 8'h00, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_state("post_rst", 0, 8'h00, 0, 0, 0, 0);
    cyc(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_state("post_push", 1, 8'h5A, 1, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer that sits directly downstream of the UART controller's RX path.
- Captures every rx_data_valid pulse (byte plus parity-error flag) into a DEPTH-entry first-word-fall-through FIFO.
- Presents the bytes to the system side over a valid/ready handshake.
- The UART RX path has no backpressure, so the block detects overflow, counts dropped bytes and reports fill status.

Parameters:
- DEPTH, 16, number of entries; power of two, >= 2.
- DATA_WIDTH, 8, byte width; matches UART rx_data.
- CNT_WIDTH, 8, width of the saturating dropped-byte counter.

Ports:
- clk  input  1  single clock domain, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- in_valid  input  1  one-cycle pulse per received byte; connects to UART rx_data_valid.
- in_data  input  DATA_WIDTH  received byte; connects to UART rx_data.
- in_error  input  1  parity-error flag for the byte; connects to UART rx_data_error.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts head entry.
- out_data  output  DATA_WIDTH  head byte.
- out_error  output  1  parity-error flag stored with the head byte.
- flush  input  1  synchronous: discard all stored entries.
- level  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
- empty  output  1  level == 0.
- full  output  1  level == DEPTH.
- overflow  output  1  sticky: at least one byte dropped since last clear.
- overflow_clear  input  1  synchronous clear of overflow and drop_count.
- drop_count  output  CNT_WIDTH  saturating count of dropped bytes.

Behaviour:
- Storage: DEPTH x (DATA_WIDTH+1) array holding {error, data}. Storage is not reset.
- Pointers: write and read pointers are $clog2(DEPTH)+1 bits wide, with the MSB used as the wrap bit.
  - empty when the pointers are fully equal.
  - full when the low bits are equal and the MSBs differ.
  - Pointers wrap naturally modulo 2*DEPTH.
- Reset (async assert, sync release) and state after reset:
  - pointers = 0, level = 0, empty = 1, full = 0, out_valid = 0.
  - out_data = 0, out_error = 0, overflow = 0, drop_count = 0.
  - Reset mid-operation discards all contents immediately.
- pop = out_valid && out_ready.
- push = in_valid && (!full || pop) && !flush.
  - Pushing when full is allowed only if a pop occurs in the same cycle.
- Latency:
  - A byte pushed at edge N gives out_valid = 1 with that byte on out_data/out_error after edge N (FWFT, one-cycle latency).
  - A byte is never visible in the same cycle it arrives (no bypass).
- out_valid = !empty.
- out_data/out_error show the entry at the read pointer when !empty, and are forced to 0 when empty.
- Handshake:
  - The head entry holds stable while out_valid && !out_ready.
  - out_ready while empty has no effect.
- level is updated every edge: +1 on push only, -1 on pop only, unchanged on both or neither. full and empty are derived from the pointers and must always agree with level.
- Drop rule: a drop occurs when in_valid && full && !pop && !flush. On a drop:
  - the byte is discarded and the FIFO is unchanged;
  - overflow <= 1;
  - drop_count increments and saturates at 2^CNT_WIDTH-1, never wrapping.
- flush (takes priority over push and pop in the same cycle):
  - pointers <= 0, level <= 0, so out_valid = 0 next cycle.
  - A byte presented with flush is discarded and not counted as a drop.
  - overflow and drop_count are unaffected.
- overflow_clear:
  - overflow <= 0 and drop_count <= 0.
  - If a drop occurs in the same cycle, the drop wins: overflow <= 1, drop_count <= 1.
- in_error is stored and returned verbatim; the FIFO never interprets it.
- No combinational path from out_ready to any output other than through registered state (out_data mux on the read pointer only).

Test Plan:
- Basic FWFT:
  - Release reset, out_ready = 0, push 0x55 (err 0) at edge 1.
  - Required: out_valid = 1, out_data = 0x55, out_error = 0, level = 1 after edge 1.
  - Assert out_ready for 1 cycle: empty = 1, out_data = 0 afterwards.
- Fill and overflow:
  - Push 0x00..0x0F with out_ready = 0: full = 1, level = 16.
  - Push 0xAA: dropped, overflow = 1, drop_count = 1.
  - Drain all 16 entries: bytes 0x00..0x0F in order, 0xAA never appears.
- Full with simultaneous push and pop:
  - At full, in_valid = 1 (0x77) with out_ready = 1 in the same cycle.
  - Required: head 0x00 popped, 0x77 accepted, level stays 16, no drop, overflow unchanged.
- Wrap-around and error flag:
  - Stream 40 bytes with alternating in_error, with out_ready toggling 1/0.
  - Required: the output sequence matches the input exactly, including error bits, and level never exceeds 16.
- Saturation and clear priority:
  - Hold full and push 300 bytes: drop_count = 255.
  - Assert overflow_clear together with one more dropped push: overflow = 1, drop_count = 1.
  - Assert overflow_clear alone: both return to 0.
- Flush and async reset:
  - With level = 5, assert flush together with in_valid (0x33): level = 0, empty = 1, drop_count unchanged, 0x33 never output.
  - Refill 3 bytes, then pulse reset low mid-cycle: all outputs return to reset values immediately, without waiting for a clock edge.
